// File: rtl/carry_lookahead_adder_32_if.sv
// Operand/result bundle for the 32-bit carry-lookahead adder.
interface carry_lookahead_adder_32_if;
    localparam int unsigned DATA_W = 32;

    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              cin;
    logic [DATA_W-1:0] sum;
    logic              cout;

    // Operand source side: drives operands, reads the registered result.
    modport master (
        output a,
        output b,
        output cin,
        input  sum,
        input  cout
    );

    // Adder side: reads operands, drives the registered result.
    modport slave (
        input  a,
        input  b,
        input  cin,
        output sum,
        output cout
    );
endinterface

// File: rtl/carry_lookahead_adder_32.sv
// 32-bit hierarchical carry-lookahead adder with registered sum/cout.
// Three lookahead levels: 4-bit groups, 16-bit sections, and a top-level
// carry into bit 16 and out of bit 31. No carry ripples between groups.
module carry_lookahead_adder_32 (
    input  logic                         clk,
    input  logic                         rst_n,
    carry_lookahead_adder_32_if.slave    bus
);
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned GROUP_W    = 4;
    localparam int unsigned NUM_GROUPS = DATA_W / GROUP_W;
    localparam int unsigned NUM_SECT   = 2;

    logic [DATA_W-1:0]     g;
    logic [DATA_W-1:0]     p;
    logic [DATA_W-1:0]     c;
    logic [NUM_GROUPS-1:0] grp_p;
    logic [NUM_GROUPS-1:0] grp_g;
    logic [NUM_GROUPS-1:0] grp_c;
    logic [NUM_SECT-1:0]   sec_p;
    logic [NUM_SECT-1:0]   sec_g;
    logic [NUM_SECT-1:0]   sec_c;
    logic                  c16;
    logic [DATA_W-1:0]     sum_c;
    logic                  cout_c;

    // Bit-level generate and propagate.
    always_comb begin
        g = bus.a & bus.b;
        p = bus.a ^ bus.b;
    end

    // Level 1: group propagate/generate for each 4-bit group.
    always_comb begin
        grp_p = '0;
        grp_g = '0;
        for (int k = 0; k < int'(NUM_GROUPS); k++) begin
            grp_p[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
            grp_g[k] = g[4*k+3]
                     | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        end
    end

    // Level 2: section propagate/generate over four groups each.
    always_comb begin
        sec_p = '0;
        sec_g = '0;
        for (int u = 0; u < int'(NUM_SECT); u++) begin
            sec_p[u] = grp_p[4*u+3] & grp_p[4*u+2] & grp_p[4*u+1] & grp_p[4*u];
            sec_g[u] = grp_g[4*u+3]
                     | (grp_p[4*u+3] & grp_g[4*u+2])
                     | (grp_p[4*u+3] & grp_p[4*u+2] & grp_g[4*u+1])
                     | (grp_p[4*u+3] & grp_p[4*u+2] & grp_p[4*u+1] & grp_g[4*u]);
        end
    end

    // Level 3: carry into bit 16 and carry out of bit 31.
    always_comb begin
        c16    = sec_g[0] | (sec_p[0] & bus.cin);
        cout_c = sec_g[1] | (sec_p[1] & c16);
        sec_c  = {c16, bus.cin};
    end

    // Level 2: group carry-ins from the section carry-in, flat sum-of-products.
    always_comb begin
        grp_c = '0;
        for (int u = 0; u < int'(NUM_SECT); u++) begin
            grp_c[4*u]   = sec_c[u];
            grp_c[4*u+1] = grp_g[4*u]
                         | (grp_p[4*u] & sec_c[u]);
            grp_c[4*u+2] = grp_g[4*u+1]
                         | (grp_p[4*u+1] & grp_g[4*u])
                         | (grp_p[4*u+1] & grp_p[4*u] & sec_c[u]);
            grp_c[4*u+3] = grp_g[4*u+2]
                         | (grp_p[4*u+2] & grp_g[4*u+1])
                         | (grp_p[4*u+2] & grp_p[4*u+1] & grp_g[4*u])
                         | (grp_p[4*u+2] & grp_p[4*u+1] & grp_p[4*u] & sec_c[u]);
        end
    end

    // Level 1: bit carries inside each group from the group carry-in.
    always_comb begin
        c = '0;
        for (int k = 0; k < int'(NUM_GROUPS); k++) begin
            c[4*k]   = grp_c[k];
            c[4*k+1] = g[4*k]
                     | (p[4*k] & grp_c[k]);
            c[4*k+2] = g[4*k+1]
                     | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & grp_c[k]);
            c[4*k+3] = g[4*k+2]
                     | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & grp_c[k]);
        end
    end

    // Sum bits.
    always_comb begin
        sum_c = p ^ c;
    end

    // Output registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.sum  <= '0;
            bus.cout <= 1'b0;
        end else begin
            bus.sum  <= sum_c;
            bus.cout <= cout_c;
        end
    end
endmodule

// File: tb/tb_carry_lookahead_adder_32.sv
// Self-checking bench for carry_lookahead_adder_32: directed cases plus
// randomized vectors against a 33-bit arithmetic reference.
module tb_carry_lookahead_adder_32;
    logic clk;
    logic rst_n;

    carry_lookahead_adder_32_if bus ();

    carry_lookahead_adder_32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int unsigned n_cmp;
    int unsigned n_err;
    logic [32:0] prev_exp;
    logic        have_prev;

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got cout/sum=%h expected %h", tag, got, exp);
        end
    endtask

    // Drive one vector, confirm the previous result is held until the edge,
    // then check the new registered result one edge later.
    task automatic apply(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic tcin, input logic trst_n);
        logic [32:0] exp;
        bus.a   = ta;
        bus.b   = tb_v;
        bus.cin = tcin;
        rst_n   = trst_n;
        #1;
        if (have_prev)
            check({tag, "_hold"}, {bus.cout, bus.sum}, prev_exp);
        @(posedge clk);
        #1;
        if (trst_n)
            exp = {1'b0, ta} + {1'b0, tb_v} + 33'(tcin);
        else
            exp = 33'd0;
        check(tag, {bus.cout, bus.sum}, exp);
        prev_exp  = exp;
        have_prev = 1'b1;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        have_prev = 1'b0;
        prev_exp  = '0;
        rst_n     = 1'b0;
        bus.a     = 32'hFFFF_FFFF;
        bus.b     = 32'hFFFF_FFFF;
        bus.cin   = 1'b1;
        @(negedge clk);

        // Reset holds outputs at zero despite all-ones operands.
        apply("rst0", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        apply("rst1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        apply("rst_rel", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
        check("rst_rel_const", {bus.cout, bus.sum}, {1'b1, 32'hFFFF_FFFF});

        // Full carry propagation.
        apply("fullprop_c1", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1);
        check("fullprop_c1_const", {bus.cout, bus.sum}, {1'b1, 32'h0000_0000});
        apply("fullprop_c0", 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1);
        check("fullprop_c0_const", {bus.cout, bus.sum}, {1'b0, 32'hFFFF_FFFF});

        // Group and section boundaries.
        apply("bnd16", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        check("bnd16_const", {bus.cout, bus.sum}, {1'b0, 32'h0001_0000});
        apply("bnd28", 32'h0FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        check("bnd28_const", {bus.cout, bus.sum}, {1'b0, 32'h1000_0000});
        for (int k = 0; k < 8; k++) begin
            logic [31:0] ones;
            ones = 32'hFFFF_FFFF >> (32 - 4*(k+1));
            apply($sformatf("grp%0d", k), ones, 32'h0000_0001, 1'b0, 1'b1);
        end

        // Mixed values.
        apply("mix0", 32'h1234_5678, 32'h8765_4321, 1'b0, 1'b1);
        check("mix0_const", {bus.cout, bus.sum}, {1'b0, 32'h9999_9999});
        apply("mix1", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1);
        check("mix1_const", {bus.cout, bus.sum}, {1'b1, 32'h0000_0001});

        // Back-to-back pipelining.
        apply("pipe0", 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1);
        check("pipe0_const", {bus.cout, bus.sum}, {1'b0, 32'h0000_0002});
        apply("pipe1", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        check("pipe1_const", {bus.cout, bus.sum}, {1'b0, 32'h8000_0000});
        apply("pipe2", 32'hFFFF_FFFE, 32'h0000_0001, 1'b1, 1'b1);
        check("pipe2_const", {bus.cout, bus.sum}, {1'b1, 32'h0000_0000});

        // Randomized vectors with occasional reset pulses.
        for (int i = 0; i < 10000; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            logic        rc;
            logic        rr;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: ra = 32'hFFFF_FFFF;
                1: rb = ~ra;
                default: ;
            endcase
            rc = 1'($urandom_range(0, 1));
            rr = ($urandom_range(0, 63) != 0);
            apply(rr ? "rand" : "rand_rst", ra, rb, rc, rr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
